// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 issue stage: opcodes, PSR bit positions,
// sequencer states and the immediate sign-extension helper.
package cr16_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_CMP   = 4'd5;
  localparam logic [3:0] OP_SUBU  = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOT   = 4'd10;
  localparam logic [3:0] OP_LSH   = 4'd11;
  localparam logic [3:0] OP_RSH   = 4'd12;
  localparam logic [3:0] OP_ALSH  = 4'd13;
  localparam logic [3:0] OP_ARSH  = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seqState_e;

  // The 7-bit immediate is two's complement; replicate its sign bit upward.
  function automatic logic [15:0] signExtendImm7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/cr16_regfile.sv
// 16x16 general-purpose register file: two operand reads and one debug read
// (all combinational), one synchronous write port, synchronous clear.
module cr16_regfile #(
  parameter int REGS = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  rdAddrA_i,
  output logic [15:0] rdDataA_o,
  input  logic [3:0]  rdAddrB_i,
  output logic [15:0] rdDataB_o,
  input  logic [3:0]  dbgAddr_i,
  output logic [15:0] dbgData_o,
  input  logic        wrEn_i,
  input  logic [3:0]  wrAddr_i,
  input  logic [15:0] wrData_i
);

  logic [15:0] regs_q [REGS];

  // Reads see the stored value, so a same-cycle write is only visible next cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn_i) begin
      regs_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdDataA_o = regs_q[rdAddrA_i];
  assign rdDataB_o = regs_q[rdAddrB_i];
  assign dbgData_o = regs_q[dbgAddr_i];

endmodule

// File: rtl/cr16_alu_sequencer.sv
// Issue stage for cr16_alu: accepts one instruction per four cycles, reads
// operands, pulses the ALU enable, then writes back the result and flags.
module cr16_alu_sequencer
  import cr16_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_INSTR_VALID,
  input  logic [15:0] I_INSTR,
  output logic        O_INSTR_READY,
  output logic [15:0] O_ALU_A,
  output logic [15:0] O_ALU_B,
  output logic [3:0]  O_ALU_OPCODE,
  output logic        O_ALU_ENABLE,
  input  logic [15:0] I_ALU_C,
  input  logic [4:0]  I_ALU_STATUS,
  output logic [4:0]  O_PSR,
  output logic        O_DONE,
  input  logic [3:0]  I_DBG_ADDR,
  output logic [15:0] O_DBG_DATA
);

  seqState_e   state_q;
  logic [15:0] instr_q;
  logic [15:0] aluA_q;
  logic [15:0] aluB_q;
  logic [3:0]  aluOp_q;
  logic        aluEn_q;
  logic [4:0]  psr_q;
  logic        done_q;

  logic [15:0] rfDataA;
  logic [15:0] rfDataB;
  logic [3:0]  opcode;
  logic [15:0] aluB_d;
  logic [3:0]  aluOp_d;
  logic        aluEn_d;
  logic        wbWrite_d;

  assign opcode = instr_q[15:12];

  cr16_regfile #(
    .REGS(REG_COUNT)
  ) u_regfile (
    .clock_i   (I_CLK),
    .reset_i   (I_RESET),
    .rdAddrA_i (instr_q[11:8]),
    .rdDataA_o (rfDataA),
    .rdAddrB_i (instr_q[3:0]),
    .rdDataB_o (rfDataB),
    .dbgAddr_i (I_DBG_ADDR),
    .dbgData_o (O_DBG_DATA),
    .wrEn_i    (wbWrite_d),
    .wrAddr_i  (instr_q[11:8]),
    .wrData_i  (I_ALU_C)
  );

  // CMP borrows the ALU's SUB; only writeback distinguishes the two.
  always_comb begin
    aluB_d    = instr_q[7] ? signExtendImm7(instr_q[6:0]) : rfDataB;
    aluOp_d   = (opcode == OP_CMP) ? OP_SUB : opcode;
    aluEn_d   = (opcode != OP_NOP);
    wbWrite_d = (state_q == ST_WB) && !I_RESET &&
                (opcode != OP_CMP) && (opcode != OP_NOP);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      aluA_q  <= '0;
      aluB_q  <= '0;
      aluOp_q <= '0;
      aluEn_q <= 1'b0;
      psr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_INSTR_VALID) begin
            instr_q <= I_INSTR;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          aluA_q  <= rfDataA;
          aluB_q  <= aluB_d;
          aluOp_q <= aluOp_d;
          aluEn_q <= aluEn_d;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          aluEn_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_WB;
        end
        ST_WB: begin
          done_q <= 1'b0;
          if (opcode != OP_NOP) begin
            psr_q <= I_ALU_STATUS;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset masks the handshake and the retire pulse in the cycle it is raised.
  assign O_INSTR_READY = (state_q == ST_IDLE) && !I_RESET;
  assign O_DONE        = done_q && !I_RESET;
  assign O_ALU_A       = aluA_q;
  assign O_ALU_B       = aluB_q;
  assign O_ALU_OPCODE  = aluOp_q;
  assign O_ALU_ENABLE  = aluEn_q;
  assign O_PSR         = psr_q;

endmodule

// File: tb/tb_cr16_alu_sequencer.sv
// Scoreboard bench for cr16_alu_sequencer paired with a one-cycle behavioural ALU.
module tb_cr16_alu_sequencer;
  import cr16_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instrValid = 1'b0;
  logic [15:0] instr = '0;
  logic        instrReady;
  logic [15:0] aluA, aluB;
  logic [3:0]  aluOp;
  logic        aluEn;
  logic [15:0] aluC = '0;
  logic [4:0]  aluStatus = '0;
  logic [4:0]  psr;
  logic        done;
  logic [3:0]  dbgAddr;
  logic [15:0] dbgData;

  logic [3:0]  stimDbgAddr = '0;
  logic [3:0]  monDbgAddr = '0;
  bit          pendingCheck = 0;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;
  int lastAccept = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    bit          en;
    logic [4:0]  psr;
    logic [3:0]  dest;
    logic [15:0] destVal;
    int          acceptCycle;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] refRegs [16];
  logic [4:0]  refPsr;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  assign dbgAddr = pendingCheck ? monDbgAddr : stimDbgAddr;

  cr16_alu_sequencer #(.REG_COUNT(16)) dut (
    .I_CLK         (clk),
    .I_RESET       (reset),
    .I_INSTR_VALID (instrValid),
    .I_INSTR       (instr),
    .O_INSTR_READY (instrReady),
    .O_ALU_A       (aluA),
    .O_ALU_B       (aluB),
    .O_ALU_OPCODE  (aluOp),
    .O_ALU_ENABLE  (aluEn),
    .I_ALU_C       (aluC),
    .I_ALU_STATUS  (aluStatus),
    .O_PSR         (psr),
    .O_DONE        (done),
    .I_DBG_ADDR    (dbgAddr),
    .O_DBG_DATA    (dbgData)
  );

  // Behavioural ALU: returns {N,Z,F,L,C, result}
  function automatic logic [20:0] aluModel(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] wide;
    logic [15:0] r;
    logic        c, f;
    c = 1'b0;
    f = 1'b0;
    r = '0;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[15:0];
        c = wide[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_SUBU: begin
        r = a - b;
        c = (a < b);
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LSH:  r = a << b[3:0];
      OP_RSH:  r = a >> b[3:0];
      OP_ALSH: r = a << b[3:0];
      OP_ARSH: r = $signed(a) >>> b[3:0];
      default: r = '0;
    endcase
    return {r[15], (r == 16'h0000), f, (a < b), c, r};
  endfunction

  always @(posedge clk) begin
    if (aluEn) {aluStatus, aluC} <= aluModel(aluOp, aluA, aluB);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic pushExpect(input logic [15:0] w, input int acceptCycle);
    exp_t e;
    int immVal;
    logic [20:0] res;
    logic [3:0] op;
    op = w[15:12];
    e.dest = w[11:8];
    e.a = refRegs[w[11:8]];
    if (w[7]) begin
      immVal = int'(w[6:0]);
      if (immVal >= 64) immVal = immVal - 128;
      e.b = 16'(immVal);
    end else begin
      e.b = refRegs[w[3:0]];
    end
    e.op = (op == OP_CMP) ? OP_SUB : op;
    e.en = (op != OP_NOP);
    if (e.en) begin
      res = aluModel(e.op, e.a, e.b);
      refPsr = res[20:16];
      if (op != OP_CMP) refRegs[w[11:8]] = res[15:0];
    end
    e.psr = refPsr;
    e.destVal = refRegs[w[11:8]];
    e.acceptCycle = acceptCycle;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] w, input bit hold);
    bit accepted = 0;
    int waits = 0;
    @(negedge clk);
    instrValid = 1'b1;
    instr = w;
    while (!accepted && waits < 20) begin
      if (instrReady) begin
        pushExpect(w, cycle);
        lastAccept = cycle;
        @(posedge clk);
        #1;
        if (!hold) instrValid = 1'b0;
        accepted = 1;
      end else begin
        @(negedge clk);
        waits++;
      end
    end
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      instrValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || pendingCheck) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0 || pendingCheck) checkOutput("drain_timeout", 0, 1);
  endtask

  task automatic checkReg(input logic [3:0] addr, input logic [15:0] expv, input string name);
    stimDbgAddr = addr;
    #1;
    checkOutput(name, dbgData, expv);
  endtask

  // Monitor: pops one expectation per retire pulse and checks it
  initial begin : monitor
    exp_t e;
    logic [15:0] seenA, seenB, expVal;
    logic [3:0]  seenOp;
    logic [4:0]  expPsr;
    bit          seenEn;
    seenEn = 0;
    seenA = '0;
    seenB = '0;
    seenOp = '0;
    expVal = '0;
    expPsr = '0;
    forever begin
      @(negedge clk);
      if (pendingCheck) begin
        checkOutput("writeback_reg", dbgData, expVal);
        checkOutput("psr", psr, expPsr);
        pendingCheck = 0;
      end
      if (aluEn) begin
        seenEn = 1;
        seenA = aluA;
        seenB = aluB;
        seenOp = aluOp;
      end
      if (reset) seenEn = 0;
      if (done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("alu_enable", seenEn, e.en);
          if (e.en) begin
            checkOutput("alu_a", seenA, e.a);
            checkOutput("alu_b", seenB, e.b);
            checkOutput("alu_opcode", seenOp, e.op);
          end
          checkOutput("done_latency", cycle - e.acceptCycle, 3);
          expVal = e.destVal;
          expPsr = e.psr;
          monDbgAddr = e.dest;
          pendingCheck = 1;
        end
        seenEn = 0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int firstAccept;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) refRegs[i] = '0;
    refPsr = '0;

    // Reset held for two cycles
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready_low", instrReady, 0);
    checkOutput("reset_psr", psr, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_alu_en", aluEn, 0);
    checkOutput("reset_alu_a", aluA, 0);
    checkOutput("reset_alu_b", aluB, 0);
    checkOutput("reset_alu_op", aluOp, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", instrReady, 1);
    for (int i = 0; i < 16; i++) checkReg(4'(i), 16'h0000, "reset_reg");

    // Directed cases
    applyStimulus(16'h0185, 0);
    waitIdle();
    checkOutput("add_imm_Z", psr[PSR_Z], 0);
    checkReg(4'd1, 16'h0005, "add_imm_r1");

    applyStimulus(16'h02FF, 0);
    waitIdle();
    checkOutput("sext_N", psr[PSR_N], 1);
    checkReg(4'd2, 16'hFFFF, "sext_r2");

    applyStimulus(16'h4101, 0);
    waitIdle();
    checkOutput("sub_Z", psr[PSR_Z], 1);
    checkReg(4'd1, 16'h0000, "sub_r1");

    applyStimulus(16'h0185, 0);
    applyStimulus(16'h5183, 0);
    waitIdle();
    checkReg(4'd1, 16'h0005, "cmp_r1_kept");
    checkOutput("cmp_C", psr[PSR_C], 0);

    applyStimulus(16'hF000, 0);
    waitIdle();

    // Reset raised during EXEC aborts the instruction
    @(negedge clk);
    instrValid = 1'b1;
    instr = 16'h0187;
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) refRegs[i] = '0;
    refPsr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("abort_no_done", done, 0);
    end
    checkReg(4'd1, 16'h0000, "abort_r1");
    checkOutput("abort_psr", psr, 0);

    // Valid held across two words
    applyStimulus(16'h0183, 1);
    firstAccept = lastAccept;
    applyStimulus(16'h0283, 0);
    checkOutput("b2b_spacing", lastAccept - firstAccept, 4);
    waitIdle();

    // Randomized instructions
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      applyStimulus(r[15:0], (i < 59) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    waitIdle();
    for (int i = 0; i < 16; i++) checkReg(4'(i), refRegs[i], "final_reg");
    checkOutput("final_psr", psr, refPsr);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
